// File: rtl/demux1_n_seq.sv
// rtl/demux1_n_seq.sv - registered 1-to-N demux with static, pulse, blink and scan modes
// Define DEMUX1N_SCAN_EN to enable the scan pointer; otherwise mode 3 behaves as mode 0.
module demux1_n_seq #(
    parameter int N_OUT    = 4,
    parameter int SEL_W    = 2,
    parameter int DATA_W   = 1,
    parameter int TICK_DIV = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       din,
    input  logic [SEL_W-1:0]        sel,
    input  logic [1:0]              mode,
    output logic [N_OUT*DATA_W-1:0] Y,
    output logic [N_OUT-1:0]        active,
    output logic                    sel_oor
);
    localparam int              CNT_W       = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [SEL_W:0]  SEL_LIMIT   = (SEL_W + 1)'(N_OUT);
    localparam logic [1:0]      MODE_STATIC = 2'd0;
    localparam logic [1:0]      MODE_PULSE  = 2'd1;
    localparam logic [1:0]      MODE_BLINK  = 2'd2;
    localparam logic [1:0]      MODE_SCAN   = 2'd3;

    logic [SEL_W-1:0]        r_sel_q;
    logic [1:0]              r_mode_q;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_phase;

    logic                    w_mode_chg;
    logic                    w_sel_chg;
    logic                    w_tick;
    logic                    w_phase_nxt;
    logic                    w_sel_big;
    logic [1:0]              w_eff_mode;
    logic [N_OUT-1:0]        w_sel_hot;
    logic [N_OUT-1:0]        w_act;
    logic [N_OUT-1:0]        w_drv;
    logic [N_OUT*DATA_W-1:0] w_y;

    assign w_mode_chg  = (mode != r_mode_q);
    assign w_sel_chg   = (sel != r_sel_q);
    assign w_tick      = (r_cnt == CNT_LAST);
    assign w_sel_big   = ({1'b0, sel} >= SEL_LIMIT);
    assign w_phase_nxt = (mode == MODE_BLINK && w_mode_chg) ? 1'b1 : (r_phase ^ w_tick);

    // Full-width compare: an out-of-range select decodes to all zeros, never a wrapped channel.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            w_sel_hot[k] = (sel == SEL_W'(k));
        end
    end

`ifdef DEMUX1N_SCAN_EN
    localparam int              PTR_W    = $clog2(N_OUT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_OUT - 1);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [N_OUT-1:0] w_ptr_hot;

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (mode == MODE_SCAN && w_mode_chg) begin
            w_ptr_nxt = '0;
        end else if (w_tick) begin
            w_ptr_nxt = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
        end
        for (int k = 0; k < N_OUT; k++) begin
            w_ptr_hot[k] = (w_ptr_nxt == PTR_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign w_eff_mode = mode;
`else
    assign w_eff_mode = (mode == MODE_SCAN) ? MODE_STATIC : mode;
`endif

    // Outputs use the post-edge phase/pointer so a toggle or advance shows on the tick edge itself.
    always_comb begin
        w_act = '0;
        w_drv = '0;
        case (w_eff_mode)
            MODE_STATIC: begin
                w_act = w_sel_hot;
                w_drv = w_sel_hot;
            end
            MODE_PULSE: begin
                if (w_mode_chg || w_sel_chg) begin
                    w_act = w_sel_hot;
                    w_drv = w_sel_hot;
                end
            end
            MODE_BLINK: begin
                w_act = w_sel_hot;
                w_drv = w_phase_nxt ? w_sel_hot : '0;
            end
            default: begin
`ifdef DEMUX1N_SCAN_EN
                w_act = w_ptr_hot;
                w_drv = w_ptr_hot;
`endif
            end
        endcase
        for (int k = 0; k < N_OUT; k++) begin
            w_y[k*DATA_W +: DATA_W] = w_drv[k] ? din : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_q  <= '0;
            r_mode_q <= '0;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
            Y        <= '0;
            active   <= '0;
            sel_oor  <= 1'b0;
        end else begin
            r_sel_q  <= sel;
            r_mode_q <= mode;
            r_cnt    <= (w_mode_chg || w_tick) ? '0 : r_cnt + 1'b1;
            r_phase  <= w_phase_nxt;
            Y        <= w_y;
            active   <= w_act;
            sel_oor  <= (w_eff_mode != MODE_SCAN) && w_sel_big;
        end
    end
endmodule

// File: tb/tb_demux1_n_seq.sv
// tb/tb_demux1_n_seq.sv - self-checking bench for demux1_n_seq (two parameter sets)
module tb_demux1_n_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [0:0]  a_din;
    logic [1:0]  a_sel;
    logic [1:0]  a_mode;
    logic [3:0]  a_y;
    logic [3:0]  a_act;
    logic        a_oor;

    logic [7:0]  b_din;
    logic [2:0]  b_sel;
    logic [1:0]  b_mode;
    logic [39:0] b_y;
    logic [4:0]  b_act;
    logic        b_oor;

    int total = 0;
    int bad = 0;

    // Reference state: previous mode/select and clocks since the last mode change.
    int pm[2];
    int ps[2];
    int tt[2];
    logic [39:0] ey_a, ey_b;
    logic [7:0]  ea_a, ea_b;
    logic        eo_a, eo_b;

    demux1_n_seq #(.N_OUT(4), .SEL_W(2), .DATA_W(1), .TICK_DIV(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(a_din), .sel(a_sel), .mode(a_mode),
        .Y(a_y), .active(a_act), .sel_oor(a_oor)
    );

    demux1_n_seq #(.N_OUT(5), .SEL_W(3), .DATA_W(8), .TICK_DIV(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(b_din), .sel(b_sel), .mode(b_mode),
        .Y(b_y), .active(b_act), .sel_oor(b_oor)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            pm[i] = 0;
            ps[i] = 0;
            tt[i] = 0;
        end
    endtask

    task automatic model_step(input int id, input int n, input int dw, input int td,
                              input int md, input int sl, input logic [7:0] d,
                              output logic [39:0] ey, output logic [7:0] ea, output logic eo);
        int  em;
        int  ch;
        bit  drive;
        bit  mchg;
        bit  schg;
        mchg = (md != pm[id]);
        schg = (sl != ps[id]);
        if (mchg) tt[id] = 0;
        else      tt[id] = tt[id] + 1;
        em = md;
`ifndef DEMUX1N_SCAN_EN
        if (md == 3) em = 0;
`endif
        ey = '0;
        ea = '0;
        eo = 1'b0;
        ch = -1;
        drive = 1'b1;
        case (em)
            0: ch = sl;
            1: ch = (mchg || schg) ? sl : -1;
            2: begin
                ch = sl;
                drive = ((tt[id] / td) % 2) == 0;
            end
            default: ch = (tt[id] / td) % n;
        endcase
        if (em != 3 && sl >= n) begin
            eo = 1'b1;
            ch = -1;
        end
        if (ch >= 0) begin
            ea[ch] = 1'b1;
            if (drive) for (int b = 0; b < dw; b++) ey[ch*dw + b] = d[b];
        end
        pm[id] = md;
        ps[id] = sl;
    endtask

    // Advance one clock and update the expected outputs of both instances.
    task automatic step();
        int am, asl, bm, bsl;
        logic [7:0] ad, bd;
        am  = int'(a_mode);
        asl = int'(a_sel);
        ad  = {7'b0, a_din};
        bm  = int'(b_mode);
        bsl = int'(b_sel);
        bd  = b_din;
        @(posedge clk);
        model_step(0, 4, 1, 8, am, asl, ad, ey_a, ea_a, eo_a);
        model_step(1, 5, 8, 4, bm, bsl, bd, ey_b, ea_b, eo_b);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_mode = 2'd0; a_din = 1'b1; a_sel = 2'd2;
        b_mode = 2'd0; b_din = 8'h00; b_sel = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (a_y !== 4'b0 || a_act !== 4'b0 || a_oor !== 1'b0 || b_y !== 40'b0 || b_act !== 5'b0 || b_oor !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: a_y=%b a_act=%b a_oor=%b b_y=%h b_act=%b b_oor=%b want all 0",
                     a_y, a_act, a_oor, b_y, b_act, b_oor);
        end
        model_reset();
        rst_n = 1'b1;
        step();
        total++;
        if (a_y !== 4'b0100 || a_act !== 4'b0100) begin
            bad++;
            $display("FAIL first_edge: Y=%b active=%b want Y=0100 active=0100", a_y, a_act);
        end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (a_y !== 4'b0 || a_act !== 4'b0) begin
            bad++;
            $display("FAIL async_reset: Y=%b active=%b want 0000/0000", a_y, a_act);
        end
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        total++;
        if (a_y !== 4'b0100) begin
            bad++;
            $display("FAIL post_reset_edge: Y=%b want 0100", a_y);
        end
    endtask

    task automatic test_pulse();
        logic [3:0] want [7] = '{4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        a_din = 1'b1;
        a_sel = 2'd0;
        a_mode = 2'd1;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) a_sel = 2'd3;
            step();
            total++;
            if (a_y !== want[i] || a_act !== want[i]) begin
                bad++;
                $display("FAIL pulse[%0d]: Y=%b active=%b want %b", i, a_y, a_act, want[i]);
            end
        end
    endtask

    task automatic test_blink();
        int         ch;
        logic [3:0] hot;
        logic [3:0] wy;
        a_din = 1'b1;
        a_sel = 2'd1;
        a_mode = 2'd2;
        for (int i = 0; i < 32; i++) begin
            if (i == 20) a_sel = 2'd2;
            ch = (i >= 20) ? 2 : 1;
            step();
            hot = 4'b0001 << ch;
            wy = (((i / 8) % 2) == 0) ? hot : 4'b0000;
            total++;
            if (a_y !== wy || a_act !== hot) begin
                bad++;
                $display("FAIL blink[%0d]: Y=%b active=%b want Y=%b active=%b", i, a_y, a_act, wy, hot);
            end
        end
    endtask

    task automatic test_scan();
        logic [39:0] wy;
        logic [4:0]  wa;
        logic        wo;
        int          ch;
        b_din = 8'hA5;
        b_sel = 3'd2;
        b_mode = 2'd3;
        for (int i = 0; i < 24; i++) begin
            step();
`ifdef DEMUX1N_SCAN_EN
            ch = (i / 4) % 5;
`else
            ch = 2;
`endif
            wa = 5'b00001 << ch;
            wy = 40'hA5 << (ch * 8);
            wo = 1'b0;
            total++;
            if (b_y !== wy || b_act !== wa || b_oor !== wo) begin
                bad++;
                $display("FAIL scan[%0d]: Y=%h active=%b oor=%b want Y=%h active=%b oor=%b",
                         i, b_y, b_act, b_oor, wy, wa, wo);
            end
        end
    endtask

    task automatic test_oor();
        b_din = 8'hA5;
        b_mode = 2'd0;
        b_sel = 3'd6;
        step();
        total++;
        if (b_y !== 40'b0 || b_act !== 5'b0 || b_oor !== 1'b1) begin
            bad++;
            $display("FAIL oor_sel6: Y=%h active=%b oor=%b want 0/0/1", b_y, b_act, b_oor);
        end
        b_sel = 3'd4;
        step();
        total++;
        if (b_y !== 40'hA5_0000_0000 || b_act !== 5'b10000 || b_oor !== 1'b0) begin
            bad++;
            $display("FAIL oor_sel4: Y=%h active=%b oor=%b want a500000000/10000/0", b_y, b_act, b_oor);
        end
        b_sel = 3'd3;
        step();
        total++;
        if (b_y !== 40'h00_A500_0000 || b_act !== 5'b01000) begin
            bad++;
            $display("FAIL byte_lane3: Y=%h active=%b want 00a5000000/01000", b_y, b_act);
        end
        b_mode = 2'd1;
        b_sel = 3'd5;
        step();
        total++;
        if (b_y !== 40'b0 || b_act !== 5'b0 || b_oor !== 1'b1) begin
            bad++;
            $display("FAIL oor_pulse: Y=%h active=%b oor=%b want 0/0/1", b_y, b_act, b_oor);
        end
        b_mode = 2'd2;
        b_sel = 3'd7;
        step();
        total++;
        if (b_y !== 40'b0 || b_act !== 5'b0 || b_oor !== 1'b1) begin
            bad++;
            $display("FAIL oor_blink: Y=%h active=%b oor=%b want 0/0/1", b_y, b_act, b_oor);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        a_din = 1'b1;
        a_mode = 2'd0;
        a_sel = 2'd0;
        step();
        a_mode = 2'd1;
        a_sel = 2'd2;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (a_act != 4'b0) pulses++;
            if (i == 0) begin
                total++;
                if (a_y !== 4'b0100) begin
                    bad++;
                    $display("FAIL entry_pulse: Y=%b want 0100", a_y);
                end
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL entry_pulse_count: got %0d want 1", pulses);
        end
        for (int i = 0; i < 4; i++) begin
            a_sel = 2'(i);
            step();
            total++;
            if (a_y !== (4'b0001 << i)) begin
                bad++;
                $display("FAIL b2b_pulse[%0d]: Y=%b want %b", i, a_y, 4'b0001 << i);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(15) == 0) a_mode = 2'($urandom_range(3));
            if ($urandom_range(15) == 0) b_mode = 2'($urandom_range(3));
            if ($urandom_range(3) == 0) a_sel = 2'($urandom_range(3));
            if ($urandom_range(3) == 0) b_sel = 3'($urandom_range(7));
            a_din = 1'($urandom_range(1));
            b_din = 8'($urandom_range(255));
            step();
            total++;
            if (a_y !== ey_a[3:0] || a_act !== ea_a[3:0] || a_oor !== eo_a) begin
                bad++;
                $display("FAIL rand_a[%0d]: Y=%b active=%b oor=%b want Y=%b active=%b oor=%b",
                         i, a_y, a_act, a_oor, ey_a[3:0], ea_a[3:0], eo_a);
            end
            total++;
            if (b_y !== ey_b || b_act !== ea_b[4:0] || b_oor !== eo_b) begin
                bad++;
                $display("FAIL rand_b[%0d]: Y=%h active=%b oor=%b want Y=%h active=%b oor=%b",
                         i, b_y, b_act, b_oor, ey_b, ea_b[4:0], eo_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_blink();
        test_scan();
        test_oor();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
